// File: rtl/bcd_display_ctrl_if.sv
// Handshake and display bus of the 3-digit BCD display controller.
// The controller side uses the slave modport; whoever feeds it uses master.
interface bcd_display_ctrl_if;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        done;
    logic [11:0] bcd;
    logic [6:0]  seg;
    logic [2:0]  dig_en;

    modport master (
        output in_valid, in_data,
        input  in_ready, done, bcd, seg, dig_en
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, done, bcd, seg, dig_en
    );
endinterface

// File: rtl/bcd_display_ctrl.sv
// Binary-to-BCD (double-dabble) converter with a multiplexed 3-digit 7-segment scan.
// Optional macro LEADING_ZERO_BLANK_EN blanks leading zero digits on the segment bus.
module bcd_display_ctrl #(
    parameter int unsigned SCAN_DIV = 50000
) (
    input logic               clk,
    input logic               rst_n,
    bcd_display_ctrl_if.slave bus
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] CONVERT = 2'd1;
    localparam logic [1:0] COMMIT  = 2'd2;

    localparam logic [19:0] SCAN_LAST = 20'(SCAN_DIV - 1);

    logic [1:0]  state;
    logic [19:0] shift_reg;
    logic [19:0] adjusted;
    logic [19:0] shifted;
    logic [2:0]  iter;
    logic [11:0] bcd_reg;
    logic        done_reg;

    logic [19:0] scan_cnt;
    logic [1:0]  digit_idx;
    logic [3:0]  digit;
    logic        blank;
    logic [6:0]  seg_code;
    logic [6:0]  seg_reg;
    logic [2:0]  dig_en_reg;

    assign bus.in_ready = (state == IDLE);
    assign bus.done     = done_reg;
    assign bus.bcd      = bcd_reg;
    assign bus.seg      = seg_reg;
    assign bus.dig_en   = dig_en_reg;

    always_comb begin
        adjusted = shift_reg;
        for (int k = 0; k < 3; k++) begin
            if (shift_reg[8 + 4*k +: 4] >= 4'd5)
                adjusted[8 + 4*k +: 4] = shift_reg[8 + 4*k +: 4] + 4'd3;
        end
        shifted = adjusted << 1;
    end

    // bcd is loaded on the final shift edge so it and done become visible together in COMMIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            shift_reg <= '0;
            iter      <= '0;
            bcd_reg   <= '0;
            done_reg  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done_reg <= 1'b0;
                    if (bus.in_valid) begin
                        shift_reg <= {12'd0, bus.in_data};
                        iter      <= '0;
                        state     <= CONVERT;
                    end
                end
                CONVERT: begin
                    shift_reg <= shifted;
                    iter      <= iter + 3'd1;
                    if (iter == 3'd7) begin
                        bcd_reg  <= shifted[19:8];
                        done_reg <= 1'b1;
                        state    <= COMMIT;
                    end
                end
                COMMIT: begin
                    done_reg <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    done_reg <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt  <= '0;
            digit_idx <= '0;
        end else if (scan_cnt == SCAN_LAST) begin
            scan_cnt  <= '0;
            digit_idx <= (digit_idx == 2'd2) ? 2'd0 : digit_idx + 2'd1;
        end else begin
            scan_cnt <= scan_cnt + 20'd1;
        end
    end

    always_comb begin
        case (digit_idx)
            2'd0:    digit = bcd_reg[3:0];
            2'd1:    digit = bcd_reg[7:4];
            2'd2:    digit = bcd_reg[11:8];
            default: digit = 4'd0;
        endcase
`ifdef LEADING_ZERO_BLANK_EN
        blank = ((digit_idx == 2'd2) && (bcd_reg[11:8] == 4'd0)) ||
                ((digit_idx == 2'd1) && (bcd_reg[11:4] == 8'd0));
`else
        blank = 1'b0;
`endif
    end

    always_comb begin
        case (digit)
            4'd0:    seg_code = 7'b1111110;
            4'd1:    seg_code = 7'b0110000;
            4'd2:    seg_code = 7'b1101101;
            4'd3:    seg_code = 7'b1111001;
            4'd4:    seg_code = 7'b0110011;
            4'd5:    seg_code = 7'b1011011;
            4'd6:    seg_code = 7'b1011111;
            4'd7:    seg_code = 7'b1110000;
            4'd8:    seg_code = 7'b1111111;
            4'd9:    seg_code = 7'b1111011;
            default: seg_code = 7'b0000000;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_reg    <= '0;
            dig_en_reg <= '0;
        end else begin
            seg_reg    <= blank ? 7'b0000000 : seg_code;
            dig_en_reg <= 3'b001 << digit_idx;
        end
    end

endmodule

// File: tb/tb_bcd_display_ctrl.sv
// Self-checking bench for bcd_display_ctrl: table-driven conversions plus
// hand-written reset, back-to-back and abort sequences.
module tb_bcd_display_ctrl;

    localparam int SCAN_DIV = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    bcd_display_ctrl_if bus ();

    bcd_display_ctrl #(.SCAN_DIV(SCAN_DIV)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  value;
        logic [11:0] exp_bcd;
    } vec_t;

    vec_t vectors[12];

    function automatic logic [6:0] encode(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1111110;
            4'd1:    return 7'b0110000;
            4'd2:    return 7'b1101101;
            4'd3:    return 7'b1111001;
            4'd4:    return 7'b0110011;
            4'd5:    return 7'b1011011;
            4'd6:    return 7'b1011111;
            4'd7:    return 7'b1110000;
            4'd8:    return 7'b1111111;
            4'd9:    return 7'b1111011;
            default: return 7'b0000000;
        endcase
    endfunction

    function automatic logic [6:0] exp_seg(input logic [11:0] b, input int idx);
        logic [3:0] d;
        d = (idx == 2) ? b[11:8] : (idx == 1) ? b[7:4] : b[3:0];
`ifdef LEADING_ZERO_BLANK_EN
        if (idx == 2 && b[11:8] == 4'd0) return 7'b0000000;
        if (idx == 1 && b[11:4] == 8'd0) return 7'b0000000;
`endif
        return encode(d);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Sends one value, scrambles in_data during conversion and checks the commit timing.
    task automatic applyStimulus(input logic [7:0] value, input logic [11:0] exp_bcd);
        int          n;
        bit          seen;
        logic [11:0] prev;
        n = 0;
        while (!bus.in_ready && n < 20) begin
            tick();
            n++;
        end
        checkOutput("ready_before_send", 32'(bus.in_ready), 32'd1);
        prev         = bus.bcd;
        bus.in_valid = 1'b1;
        bus.in_data  = value;
        tick();
        bus.in_valid = 1'b0;
        bus.in_data  = ~value;
        checkOutput("ready_drop", 32'(bus.in_ready), 32'd0);
        seen = 1'b0;
        n    = 0;
        while (!seen && n < 20) begin
            tick();
            n++;
            seen = bus.done;
            if (!seen) checkOutput("bcd_hold", 32'(bus.bcd), 32'(prev));
        end
        checkOutput("done_seen", 32'(seen), 32'd1);
        checkOutput("done_latency", 32'(n), 32'd8);
        checkOutput("bcd_value", 32'(bus.bcd), 32'(exp_bcd));
        tick();
        checkOutput("done_one_cycle", 32'(bus.done), 32'd0);
        checkOutput("ready_again", 32'(bus.in_ready), 32'd1);
    endtask

    task automatic scanCheck(input logic [11:0] b);
        int         idx;
        logic [2:0] seen_mask;
        seen_mask = 3'b000;
        for (int i = 0; i < 12; i++) begin
            tick();
            case (bus.dig_en)
                3'b001:  idx = 0;
                3'b010:  idx = 1;
                3'b100:  idx = 2;
                default: idx = -1;
            endcase
            if (idx < 0) begin
                checkOutput("dig_en_onehot", 32'(bus.dig_en), 32'd1);
            end else begin
                seen_mask[idx] = 1'b1;
                checkOutput($sformatf("seg_idx%0d_bcd%03h", idx, b), 32'(bus.seg), 32'(exp_seg(b, idx)));
            end
        end
        checkOutput("scan_all_digits", 32'(seen_mask), 32'h7);
    endtask

    initial begin
        int          acc_cyc[3];
        int          na, nd, cyc, dcount;
        bit          acc;
        logic [7:0]  bb_val[3];
        logic [11:0] bb_exp[3];

        vectors[0]  = '{8'd198, 12'h198};
        vectors[1]  = '{8'd255, 12'h255};
        vectors[2]  = '{8'd0,   12'h000};
        vectors[3]  = '{8'd9,   12'h009};
        vectors[4]  = '{8'd7,   12'h007};
        vectors[5]  = '{8'd40,  12'h040};
        vectors[6]  = '{8'd99,  12'h099};
        vectors[7]  = '{8'd100, 12'h100};
        vectors[8]  = '{8'd5,   12'h005};
        vectors[9]  = '{8'd50,  12'h050};
        vectors[10] = '{8'd137, 12'h137};
        vectors[11] = '{8'd208, 12'h208};

        bus.in_valid = 1'b0;
        bus.in_data  = 8'd0;
        rst_n        = 1'b0;
        tick();
        tick();
        checkOutput("rst_bcd", 32'(bus.bcd), 32'h000);
        checkOutput("rst_done", 32'(bus.done), 32'd0);
        checkOutput("rst_ready", 32'(bus.in_ready), 32'd1);
        checkOutput("rst_seg", 32'(bus.seg), 32'd0);
        checkOutput("rst_dig_en", 32'(bus.dig_en), 32'd0);

        rst_n = 1'b1;
        for (int i = 0; i < 13; i++) begin
            tick();
            checkOutput($sformatf("scan_dig_en_%0d", i), 32'(bus.dig_en), 32'(3'b001 << ((i / 4) % 3)));
            checkOutput($sformatf("scan_seg_%0d", i), 32'(bus.seg), 32'(exp_seg(12'h000, (i / 4) % 3)));
        end

        for (int v = 0; v < 12; v++) begin
            applyStimulus(vectors[v].value, vectors[v].exp_bcd);
            scanCheck(vectors[v].exp_bcd);
        end

        // Back-to-back with in_valid held: each value must be taken exactly once, 10 cycles apart.
        bb_val = '{8'd255, 8'd0, 8'd9};
        bb_exp = '{12'h255, 12'h000, 12'h009};
        na = 0; nd = 0; cyc = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = bb_val[0];
        while (nd < 3 && cyc < 60) begin
            acc = bus.in_ready && bus.in_valid;
            tick();
            cyc++;
            if (acc) begin
                acc_cyc[na] = cyc;
                na++;
                if (na < 3) bus.in_data = bb_val[na];
                else        bus.in_valid = 1'b0;
            end
            if (bus.done) begin
                if (nd < 3) checkOutput($sformatf("b2b_bcd_%0d", nd), 32'(bus.bcd), 32'(bb_exp[nd]));
                nd++;
            end
        end
        bus.in_valid = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (bus.done) nd++;
        end
        checkOutput("b2b_accepts", 32'(na), 32'd3);
        checkOutput("b2b_dones", 32'(nd), 32'd3);
        if (na == 3) begin
            checkOutput("b2b_gap_1", 32'(acc_cyc[1] - acc_cyc[0]), 32'd10);
            checkOutput("b2b_gap_2", 32'(acc_cyc[2] - acc_cyc[1]), 32'd10);
        end

        applyStimulus(8'd42, 12'h042);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'd137;
        tick();
        bus.in_valid = 1'b0;
        tick();
        tick();
        tick();
        #1 rst_n = 1'b0;
        #1;
        checkOutput("abort_bcd", 32'(bus.bcd), 32'h000);
        checkOutput("abort_done", 32'(bus.done), 32'd0);
        checkOutput("abort_ready", 32'(bus.in_ready), 32'd1);
        tick();
        rst_n = 1'b1;
        dcount = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (bus.done) dcount++;
        end
        checkOutput("abort_no_done", 32'(dcount), 32'd0);
        checkOutput("abort_bcd_after", 32'(bus.bcd), 32'h000);
        applyStimulus(8'd137, 12'h137);
        scanCheck(12'h137);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
